// File: rtl/pln_pkg.sv
// Shared definitions for the PLN memory subsystem.
// Arbiter FSM encoding and default bus widths.
package pln_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;

  localparam int PLN_ADDR_W = 16;
  localparam int PLN_DATA_W = 16;

endpackage

// File: rtl/pln_rr_pick2.sv
// Two-way request picker: round-robin on a tie,
// or port 1 first when fixed priority is selected.
module pln_rr_pick2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  input  logic       fixed_i,
  output logic [1:0] gnt_o,
  output logic       valid_o
);

  always_comb begin
    gnt_o = 2'b00;
    unique case (1'b1)
      (req_i == 2'b11):
        gnt_o = (fixed_i || !last_i) ? 2'b10 : 2'b01;
      (req_i == 2'b01): gnt_o = 2'b01;
      (req_i == 2'b10): gnt_o = 2'b10;
      default:          gnt_o = 2'b00;
    endcase
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/pln_mem_arbiter.sv
// Two-port arbiter sharing one single-port synchronous RAM
// between instruction fetch (port 0) and data access (port 1).
module pln_mem_arbiter
  import pln_pkg::*;
#(
  parameter int ADDR_W     = PLN_ADDR_W,
  parameter int DATA_W     = PLN_DATA_W,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  logic [1:0]        state_q, state_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        ack_q, ack_d;
  logic              win_q, win_d;
  logic              we_q, we_d;
  logic              last_q, last_d;
  logic              en_q, en_d;
  logic              mwe_q, mwe_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rd0_q, rd0_d;
  logic [DATA_W-1:0] rd1_q, rd1_d;

  logic [1:0] pick;
  logic       pick_vld;
  logic       decide;

  pln_rr_pick2 u_pick (
    .req_i   ({p1_req, p0_req}),
    .last_i  (last_q),
    .fixed_i (FIXED_PRIO != 0),
    .gnt_o   (pick),
    .valid_o (pick_vld)
  );

  assign decide = (state_q == ST_IDLE) ||
                  (state_q == ST_CAPTURE);

  always_comb begin
    state_d = state_q;
    gnt_d   = 2'b00;
    ack_d   = 2'b00;
    win_d   = win_q;
    we_d    = we_q;
    last_d  = last_q;
    en_d    = 1'b0;
    mwe_d   = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd0_d   = rd0_q;
    rd1_d   = rd1_q;

    if (state_q == ST_ISSUE)
      state_d = ST_CAPTURE;

    // RAM data is valid now; retire the access
    if (state_q == ST_CAPTURE) begin
      ack_d = win_q ? 2'b10 : 2'b01;
      if (!we_q) begin
        if (win_q) rd1_d = mem_rdata;
        else       rd0_d = mem_rdata;
      end
    end

    if (decide) begin
      if (pick_vld) begin
        state_d = ST_ISSUE;
        gnt_d   = pick;
        win_d   = pick[1];
        last_d  = pick[1];
        we_d    = pick[1] ? p1_we : p0_we;
        en_d    = 1'b1;
        mwe_d   = pick[1] ? p1_we : p0_we;
        addr_d  = pick[1] ? p1_addr : p0_addr;
        wdata_d = pick[1] ? p1_wdata : p0_wdata;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= 2'b00;
      ack_q   <= 2'b00;
      win_q   <= 1'b0;
      we_q    <= 1'b0;
      last_q  <= 1'b1;
      en_q    <= 1'b0;
      mwe_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd0_q   <= '0;
      rd1_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      win_q   <= win_d;
      we_q    <= we_d;
      last_q  <= last_d;
      en_q    <= en_d;
      mwe_q   <= mwe_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
    end
  end

  assign p0_gnt    = gnt_q[0];
  assign p1_gnt    = gnt_q[1];
  assign p0_ack    = ack_q[0];
  assign p1_ack    = ack_q[1];
  assign p0_rdata  = rd0_q;
  assign p1_rdata  = rd1_q;
  assign mem_en    = en_q;
  assign mem_we    = mwe_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pln_mem_arbiter.sv
// Directed bench for pln_mem_arbiter: round-robin and
// fixed-priority instances share stimulus, each with its own RAM.
module tb_pln_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
  logic [15:0] p0_addr = 0, p0_wdata = 0, p1_addr = 0, p1_wdata = 0;

  logic        p0_gnt, p0_ack, p1_gnt, p1_ack, mem_en, mem_we, busy;
  logic [15:0] p0_rdata, p1_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        f_p0_gnt, f_p0_ack, f_p1_gnt, f_p1_ack;
  logic        f_mem_en, f_mem_we, f_busy;
  logic [15:0] f_p0_rdata, f_p1_rdata, f_mem_addr, f_mem_wdata;
  logic [15:0] f_mem_rdata;

  logic [15:0] ram0 [256];
  logic [15:0] ram1 [256];

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  pln_mem_arbiter #(.FIXED_PRIO(0)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_ack(p0_ack),
    .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_ack(p1_ack),
    .p1_rdata(p1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  pln_mem_arbiter #(.FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_gnt(f_p0_gnt), .p0_ack(f_p0_ack),
    .p0_rdata(f_p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_gnt(f_p1_gnt), .p1_ack(f_p1_ack),
    .p1_rdata(f_p1_rdata),
    .mem_en(f_mem_en), .mem_we(f_mem_we), .mem_addr(f_mem_addr),
    .mem_wdata(f_mem_wdata), .mem_rdata(f_mem_rdata),
    .busy(f_busy)
  );

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram0[i] = 16'h0000;
      ram1[i] = 16'h0000;
    end
    ram0[8'h10] = 16'hBEEF;
    ram1[8'h10] = 16'hBEEF;
    ram0[8'hFF] = 16'hC3C3;
    ram1[8'hFF] = 16'hC3C3;
  end

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram0[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= ram0[mem_addr[7:0]];
    end
    if (f_mem_en) begin
      if (f_mem_we) ram1[f_mem_addr[7:0]] <= f_mem_wdata;
      else          f_mem_rdata <= ram1[f_mem_addr[7:0]];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    p0_req = 1'b0;
    p1_req = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_req(input int port, input logic we,
                         input logic [15:0] a, input logic [15:0] d);
    if (port == 0) begin
      p0_req = 1'b1; p0_we = we; p0_addr = a; p0_wdata = d;
    end else begin
      p1_req = 1'b1; p1_we = we; p1_addr = a; p1_wdata = d;
    end
  endtask

  // Single access on the round-robin instance, checked cycle by cycle
  task automatic access(input int port, input logic we,
                        input logic [15:0] a, input logic [15:0] d,
                        input logic [15:0] exp_rd);
    logic [1:0] oh;
    oh = (port == 0) ? 2'b01 : 2'b10;
    set_req(port, we, a, d);
    tick();
    chk("c1_gnt", {p1_gnt, p0_gnt}, oh);
    chk("c1_mem", {mem_en, mem_we, mem_addr}, {1'b1, we, a});
    if (we) chk("c1_wdata", mem_wdata, d);
    chk("c1_ack", {p1_ack, p0_ack}, 2'b00);
    p0_req = 1'b0;
    p1_req = 1'b0;
    tick();
    chk("c2_gnt_ack_en", {p1_gnt, p0_gnt, p1_ack, p0_ack, mem_en, mem_we},
        6'b0);
    chk("c2_busy", busy, 1'b1);
    tick();
    chk("c3_ack", {p1_ack, p0_ack}, oh);
    chk("c3_rdata", (port == 0) ? p0_rdata : p1_rdata, exp_rd);
    chk("c3_gnt_en", {p1_gnt, p0_gnt, mem_en}, 3'b0);
  endtask

  typedef struct {
    int          port;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t vt [9];

  initial begin
    logic [1:0] eg, ea;

    vt[0] = '{0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF};
    vt[1] = '{1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF};
    vt[2] = '{1, 1'b1, 16'h0020, 16'h1234, 16'hBEEF};
    vt[3] = '{0, 1'b0, 16'h0020, 16'h0000, 16'h1234};
    vt[4] = '{0, 1'b1, 16'h0030, 16'h5A5A, 16'h1234};
    vt[5] = '{1, 1'b0, 16'h0030, 16'h0000, 16'h5A5A};
    vt[6] = '{1, 1'b0, 16'hFFFF, 16'h0000, 16'hC3C3};
    vt[7] = '{0, 1'b1, 16'hFFFF, 16'h0001, 16'h1234};
    vt[8] = '{0, 1'b0, 16'hFFFF, 16'h0000, 16'h0001};

    do_reset();
    chk("rst_out", {p0_gnt, p1_gnt, p0_ack, p1_ack, mem_en, mem_we, busy},
        7'b0);
    chk("rst_data", {p0_rdata, p1_rdata, mem_addr, mem_wdata}, 64'h0);
    chk("rst_fp_out", {f_p0_gnt, f_p1_gnt, f_p0_ack, f_p1_ack, f_busy},
        5'b0);

    for (int i = 0; i < 9; i++)
      access(vt[i].port, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].exp_rd);

    // Both ports saturated: strict alternation from p0
    do_reset();
    set_req(0, 1'b0, 16'h0010, 16'h0);
    set_req(1, 1'b0, 16'h0030, 16'h0);
    for (int i = 1; i <= 17; i++) begin
      tick();
      eg = 2'b00;
      ea = 2'b00;
      if (i % 2 == 1 && i <= 15) eg = (((i - 1) / 2) % 2 == 0) ? 2'b01 : 2'b10;
      if (i % 2 == 1 && i >= 3)  ea = (((i - 3) / 2) % 2 == 0) ? 2'b01 : 2'b10;
      chk("rr_gnt", {p1_gnt, p0_gnt}, eg);
      chk("rr_ack", {p1_ack, p0_ack}, ea);
      if (ea == 2'b01) chk("rr_rd0", p0_rdata, 16'hBEEF);
      if (ea == 2'b10) chk("rr_rd1", p1_rdata, 16'h5A5A);
      if (i == 15) begin
        p0_req = 1'b0;
        p1_req = 1'b0;
      end
    end
    chk("rr_idle", busy, 1'b0);

    // Fixed priority: p1 monopolises until it drops
    do_reset();
    set_req(0, 1'b0, 16'h0010, 16'h0);
    set_req(1, 1'b0, 16'h0030, 16'h0);
    for (int i = 1; i <= 11; i++) begin
      tick();
      eg = 2'b00;
      ea = 2'b00;
      if (i % 2 == 1 && i <= 7) eg = 2'b10;
      if (i == 9)               eg = 2'b01;
      if (i % 2 == 1 && i >= 3 && i <= 9) ea = 2'b10;
      if (i == 11)              ea = 2'b01;
      chk("fp_gnt", {f_p1_gnt, f_p0_gnt}, eg);
      chk("fp_ack", {f_p1_ack, f_p0_ack}, ea);
      if (i == 7) p1_req = 1'b0;
      if (i == 9) p0_req = 1'b0;
    end
    chk("fp_rd0", f_p0_rdata, 16'hBEEF);

    // Reset during ISSUE of a write abandons it
    do_reset();
    set_req(1, 1'b1, 16'h0040, 16'hAAAA);
    tick();
    chk("r5_gnt", {p1_gnt, mem_en, mem_we}, 3'b111);
    p1_req = 1'b0;
    rst    = 1'b1;
    #1;
    chk("r5_drop", {p1_gnt, mem_en, mem_we, busy}, 4'b0);
    tick();
    chk("r5_noack1", {p1_ack, p0_ack}, 2'b00);
    tick();
    chk("r5_noack2", {p1_ack, p0_ack}, 2'b00);
    rst = 1'b0;
    tick();
    access(1, 1'b0, 16'h0040, 16'h0, 16'h0000);

    // Request raised during ISSUE is granted straight from CAPTURE
    set_req(1, 1'b0, 16'h0030, 16'h0);
    tick();
    chk("r6_g1", {p1_gnt, p0_gnt}, 2'b10);
    p1_req = 1'b0;
    set_req(0, 1'b0, 16'h0010, 16'h0);
    tick();
    chk("r6_cap", {busy, p1_gnt, p0_gnt}, 3'b100);
    tick();
    chk("r6_back2back", {p0_gnt, p1_ack, busy}, 3'b111);
    chk("r6_rd1", p1_rdata, 16'h5A5A);
    p0_req = 1'b0;
    tick();
    tick();
    chk("r6_ack0", {p1_ack, p0_ack}, 2'b01);
    chk("r6_rd0", p0_rdata, 16'hBEEF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
